regfile_bypass_clr: RTL and testbench
=====================================

Name: regfile_bypass_clr

Overview:
- 2-read/1-write register file, the responder to the register-file test bench's stimulus interface. Port names and semantics are unchanged: WriteData, WriteRegister, RegWrite, ReadRegister1/2, ReadData1/2, Clk.
- Adds an async-reset hardware clear sequence and a one-stage registered write-back with read bypass.
- Register 0 is hardwired to zero.
- Write-then-read behaviour seen by any driver is identical to a plain single-cycle register file.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, address width; depth = 2**ADDR_W.

Ports:
- Clk  input  1  clock, rising edge active.
- Reset  input  1  asynchronous, active-high reset.
- WriteData  input  WIDTH  data to write.
- WriteRegister  input  ADDR_W  write address.
- RegWrite  input  1  write enable, sampled on rising Clk.
- ReadRegister1  input  ADDR_W  port-1 read address.
- ReadRegister2  input  ADDR_W  port-2 read address.
- ReadData1  output  WIDTH  port-1 read data (combinational).
- ReadData2  output  WIDTH  port-2 read data (combinational).
- Ready  output  1  high once the clear sequence has completed.
- WriteDropped  output  1  one-cycle pulse when a write request is discarded.

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-high, Reset.
- Reset assertion, immediate and independent of Clk:
  - state=CLEAR, ClrIdx=1.
  - Ready=0, WriteDropped=0.
  - WbValid=0; any pending write-back is discarded.
  - ReadData1/2 read 0 while Ready=0.
- CLEAR state:
  - Each rising edge after Reset deasserts writes 0 to reg[ClrIdx], then ClrIdx++.
  - After the edge that clears reg[2**ADDR_W-1], state=READY and Ready=1.
  - Ready is therefore low for exactly 31 edges after deassertion (ADDR_W=5).
- Writes during CLEAR: RegWrite=1 is not captured. WriteDropped=1 for the following cycle. The array is unaffected.
- READY state, write capture: on a rising edge with RegWrite=1 and WriteRegister!=0, load WbValid=1, WbAddr=WriteRegister, WbData=WriteData.
- READY state, commit: on the same edge, a previously valid Wb entry commits to reg[WbAddr].
- READY state, idle: RegWrite=0 or WriteRegister=0 gives WbValid=0 after the edge. A write to register 0 is silently ignored; WriteDropped is not pulsed.
- Read path, per port:
  - Address 0 returns 0.
  - Else, if WbValid and WbAddr==address, returns WbData (bypass).
  - Else returns reg[address].
- Latency: data written at edge N is readable on both ports immediately after edge N, via bypass, and resides in the array from edge N+1.
- Back-to-back writes to the same address: the newer value wins. The old Wb entry commits and the new one is captured on the same edge, and bypass shows the newer value.
- Back-to-back writes to different addresses: both land; no stalls, no lost writes.
- Reset mid-operation:
  - Pending Wb is discarded and the clear restarts from index 1.
  - All registers read 0 after Ready rises again.
- State encoding: 2 states (CLEAR, READY); there is no other reachable state. Illegal encodings go to CLEAR.
- Widths: ClrIdx is ADDR_W bits. Terminal condition ClrIdx == all-ones; no wrap into index 0.

Decomposition:
- Package regfile_pkg holds:
  - WIDTH and ADDR_W defaults.
  - the state enum {CLEAR, READY}.
  - a ZERO_REG address constant.
- Sub-module regfile_clear_fsm owns state, ClrIdx, Ready and WriteDropped generation. It outputs clr_we and clr_addr to the array.
- The top level holds the array, the Wb stage, the write mux (clear vs commit) and the bypass/read muxes.

Test Plan:
- Reset pulse of 3 cycles, then free-run Clk -> Ready=0 for 31 edges, Ready=1 after the 31st; ReadData1/2=0 throughout.
- After Ready: write 42 to r2, one edge, read r2 on both ports -> 42/42. Write 15 to r2 -> 15/15. RegWrite=0 with data 16 -> still 15.
- Write 13 to r2, ReadRegister2=1 -> port1=13, port2=0 (decoder not broadcast). Write 1 to r0 -> reads 0, WbValid stays 0.
- RegWrite=1 to r5 during CLEAR -> WriteDropped high one cycle; after Ready r5=0.
- Back-to-back r5=1 then r5=2, followed by r6=3 -> r5=2 and r6=3 on both ports immediately and 5 idle edges later.
- Write 17 to r17, then assert Reset between edges while Wb is pending -> after Ready returns, r17=0. Sweep r0..r31 on both ports -> all 0, and port2 never returns 17.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, controller state type and the hardwired-zero register index
// used by the bypassed, hardware-cleared register file.
package regfile_pkg;
    localparam int REGFILE_WIDTH  = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;
endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: after reset, zeroes registers 1..2**ADDR_W-1 one per edge,
// then raises Ready; flags writes that arrive before the array is usable.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_reg_write,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_ready,
    output logic              o_write_dropped
);
    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_dropped;
    logic              w_last;
    logic              w_clearing;

    assign w_last     = (r_clr_idx == '1);
    assign w_clearing = (r_state != READY);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= ADDR_W'(1);
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dropped <= w_clearing && i_reg_write;
            // Hold at the top index once reached so the sweep never wraps to 0.
            if (w_clearing && !w_last)
                r_clr_idx <= r_clr_idx + ADDR_W'(1);
        end
    end

    always_comb begin
        w_next = CLEAR;
        case (r_state)
            CLEAR:   w_next = w_last ? READY : CLEAR;
            READY:   w_next = READY;
            default: w_next = CLEAR;
        endcase
    end

    assign o_clr_we        = w_clearing;
    assign o_clr_addr      = r_clr_idx;
    assign o_ready         = !w_clearing;
    assign o_write_dropped = r_dropped;
endmodule

// File: rtl/regfile_bypass_clr.sv
// 2R/1W register file with hardware clear after reset and a one-stage
// registered write-back whose pending entry is bypassed onto both read ports.
module regfile_bypass_clr
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              Ready,
    output logic              WriteDropped
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;
    logic              w_capture;
    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [WIDTH-1:0]  r_wb_data;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [WIDTH-1:0]  w_arr_data;
    logic [WIDTH-1:0]  r_mem [0:(1<<ADDR_W)-1];

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .Clk             (Clk),
        .Reset           (Reset),
        .i_reg_write     (RegWrite),
        .o_clr_we        (w_clr_we),
        .o_clr_addr      (w_clr_addr),
        .o_ready         (w_ready),
        .o_write_dropped (WriteDropped)
    );

    assign w_capture = w_ready && RegWrite && (WriteRegister != ZERO_ADDR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_wb_valid <= 1'b0;
        else       r_wb_valid <= w_capture;
    end

    always_ff @(posedge Clk) begin
        if (w_capture) begin
            r_wb_addr <= WriteRegister;
            r_wb_data <= WriteData;
        end
    end

    // Clear and commit never overlap: the Wb entry is always invalid while clearing.
    assign w_arr_we   = w_clr_we || (w_ready && r_wb_valid);
    assign w_arr_addr = w_clr_we ? w_clr_addr : r_wb_addr;
    assign w_arr_data = w_clr_we ? '0 : r_wb_data;

    always_ff @(posedge Clk) begin
        if (w_arr_we) r_mem[w_arr_addr] <= w_arr_data;
    end

    assign ReadData1 = (!w_ready || ReadRegister1 == ZERO_ADDR) ? '0 :
                       (r_wb_valid && r_wb_addr == ReadRegister1) ? r_wb_data :
                       r_mem[ReadRegister1];
    assign ReadData2 = (!w_ready || ReadRegister2 == ZERO_ADDR) ? '0 :
                       (r_wb_valid && r_wb_addr == ReadRegister2) ? r_wb_data :
                       r_mem[ReadRegister2];

    assign Ready = w_ready;
endmodule

// File: tb/tb_regfile_bypass_clr.sv
// Directed bench for regfile_bypass_clr: clear sequence, write/bypass vectors,
// dropped writes during clear and reset while a write-back is pending.
module tb_regfile_bypass_clr;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] WriteData = '0;
    logic [4:0]  WriteRegister = '0;
    logic        RegWrite = 1'b0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Ready;
    logic        WriteDropped;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_bypass_clr #(.WIDTH(32), .ADDR_W(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .WriteData     (WriteData),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Ready         (Ready),
        .WriteDropped  (WriteDropped)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input int exp_edges, input string name);
        int edges;
        edges = 0;
        while (!Ready && edges < 40) begin
            chk({name, "_rd1_clr"}, ReadData1, 32'd0);
            chk({name, "_rd2_clr"}, ReadData2, 32'd0);
            step();
            edges++;
        end
        chk({name, "_edges"}, edges, exp_edges);
        chk({name, "_ready"}, Ready, 1'b1);
    endtask

    initial begin
        // Power-on reset for 3 edges, with a dropped write to r5 mid-clear.
        #2 Reset = 1'b1;
        #1;
        chk("rst_ready", Ready, 1'b0);
        chk("rst_drop", WriteDropped, 1'b0);
        chk("rst_rd1", ReadData1, 32'd0);
        repeat (3) step();
        Reset = 1'b0;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd31;
        for (int i = 1; i <= 31; i++) begin
            RegWrite      = (i == 10);
            WriteRegister = 5'd5;
            WriteData     = 32'd99;
            step();
            RegWrite = 1'b0;
            chk($sformatf("clr_ready_e%0d", i), Ready, (i == 31));
            chk($sformatf("clr_drop_e%0d", i), WriteDropped, (i == 10));
            if (i < 31) begin
                chk($sformatf("clr_rd1_e%0d", i), ReadData1, 32'd0);
                chk($sformatf("clr_rd2_e%0d", i), ReadData2, 32'd0);
            end
        end
        step();
        chk("drop_after_ready", WriteDropped, 1'b0);

        // Table-driven write/bypass vectors in READY.
        vecs.push_back('{1'b0, 5'd5,  32'd0,  5'd5,  5'd5,  32'd0,  32'd0});
        vecs.push_back('{1'b1, 5'd2,  32'd42, 5'd2,  5'd2,  32'd42, 32'd42});
        vecs.push_back('{1'b1, 5'd2,  32'd15, 5'd2,  5'd2,  32'd15, 32'd15});
        vecs.push_back('{1'b0, 5'd2,  32'd16, 5'd2,  5'd2,  32'd15, 32'd15});
        vecs.push_back('{1'b1, 5'd2,  32'd13, 5'd2,  5'd1,  32'd13, 32'd0});
        vecs.push_back('{1'b1, 5'd0,  32'd1,  5'd0,  5'd2,  32'd0,  32'd13});
        vecs.push_back('{1'b1, 5'd5,  32'd1,  5'd5,  5'd5,  32'd1,  32'd1});
        vecs.push_back('{1'b1, 5'd5,  32'd2,  5'd5,  5'd5,  32'd2,  32'd2});
        vecs.push_back('{1'b1, 5'd6,  32'd3,  5'd5,  5'd6,  32'd2,  32'd3});
        vecs.push_back('{1'b0, 5'd6,  32'd77, 5'd6,  5'd5,  32'd3,  32'd2});
        vecs.push_back('{1'b0, 5'd6,  32'd77, 5'd5,  5'd6,  32'd2,  32'd3});
        vecs.push_back('{1'b0, 5'd6,  32'd77, 5'd6,  5'd6,  32'd3,  32'd3});
        vecs.push_back('{1'b0, 5'd6,  32'd77, 5'd5,  5'd5,  32'd2,  32'd2});
        vecs.push_back('{1'b0, 5'd6,  32'd77, 5'd5,  5'd6,  32'd2,  32'd3});
        vecs.push_back('{1'b1, 5'd17, 32'd17, 5'd17, 5'd17, 32'd17, 32'd17});
        foreach (vecs[k]) begin
            RegWrite      = vecs[k].we;
            WriteRegister = vecs[k].wa;
            WriteData     = vecs[k].wd;
            ReadRegister1 = vecs[k].ra1;
            ReadRegister2 = vecs[k].ra2;
            step();
            chk($sformatf("vec%0d_rd1", k), ReadData1, vecs[k].e1);
            chk($sformatf("vec%0d_rd2", k), ReadData2, vecs[k].e2);
            chk($sformatf("vec%0d_drop", k), WriteDropped, 1'b0);
        end
        RegWrite = 1'b0;

        // Reset between edges while the r17 write-back is still pending.
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_ready", Ready, 1'b0);
        chk("mid_rst_rd1", ReadData1, 32'd0);
        chk("mid_rst_rd2", ReadData2, 32'd0);
        repeat (2) step();
        Reset = 1'b0;
        wait_ready(31, "re_clear");

        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            chk($sformatf("sweep_p1_r%0d", a), ReadData1, 32'd0);
            chk($sformatf("sweep_p2_r%0d", 31 - a), ReadData2, 32'd0);
        end
        ReadRegister1 = 5'd17;
        ReadRegister2 = 5'd17;
        step();
        chk("r17_p1_after_idle", ReadData1, 32'd0);
        chk("r17_p2_after_idle", ReadData2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
